// File: rtl/pb_debounce_pkg.sv
// Shared types and default constants for the push-button debouncer slice.
package pb_debounce_pkg;

    typedef enum logic {
        ST_STABLE,
        ST_SETTLING
    } db_state_t;

    localparam int DEF_SYNC_STAGES  = 2;
    localparam int DEF_TICK_DIV     = 100000;
    localparam int DEF_STABLE_TICKS = 20;

    // Counter width for a modulus, never narrower than one bit.
    function automatic int min1_clog2(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/pb_debounce_channel.sv
// One debounce channel: pin synchroniser, stability-window FSM and registered
// level plus rise/fall pulses.
module debounce_channel
    import pb_debounce_pkg::*;
#(
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    input  logic tick,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int              CW       = min1_clog2(STABLE_TICKS);
    localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_TICKS - 1);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync;

    db_state_t   state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic        level_nxt;
    logic        rise_nxt;
    logic        fall_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], pin};
        end
    end

    assign sync = sync_ff[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_STABLE;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            level <= level_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
        end
    end

    // A revert to the current level takes priority over the final tick, so a
    // glitch that ends exactly on the closing tick never reaches the output.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        level_nxt = level;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        case (state)
            ST_STABLE: begin
                if (sync != level) begin
                    state_nxt = ST_SETTLING;
                    cnt_nxt   = '0;
                end
            end
            ST_SETTLING: begin
                if (sync == level) begin
                    state_nxt = ST_STABLE;
                    cnt_nxt   = '0;
                end else if (tick && (cnt == CNT_LAST)) begin
                    level_nxt = sync;
                    rise_nxt  = sync;
                    fall_nxt  = ~sync;
                    state_nxt = ST_STABLE;
                    cnt_nxt   = '0;
                end else if (tick) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_STABLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/pb_debounce.sv
// Multi-channel push-button conditioner: one shared sample-tick prescaler
// feeding an array of independent debounce channels.
module pb_debounce
    import pb_debounce_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int TICK_DIV     = DEF_TICK_DIV,
    parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] pb_in,
    output logic [NUM_CH-1:0] sig_debounced_out,
    output logic [NUM_CH-1:0] rise_pulse,
    output logic [NUM_CH-1:0] fall_pulse
);

    localparam int            PW        = min1_clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc;
    logic          tick;

    assign tick = (presc == PRESC_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_TICKS (STABLE_TICKS)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .pin   (pb_in[g]),
            .tick  (tick),
            .level (sig_debounced_out[g]),
            .rise  (rise_pulse[g]),
            .fall  (fall_pulse[g])
        );
    end

endmodule

// File: tb/tb_pb_debounce.sv
// Scoreboard bench for pb_debounce: expected pulse events are queued when a pin
// changes and matched against pulses seen by a negedge monitor.
module tb_pb_debounce;

    localparam int NUM_CH       = 4;
    localparam int SYNC_STAGES  = 2;
    localparam int TICK_DIV     = 4;
    localparam int STABLE_TICKS = 3;
    localparam int LAT_MIN = SYNC_STAGES + (STABLE_TICKS - 1) * TICK_DIV + 1;
    localparam int LAT_MAX = SYNC_STAGES + (STABLE_TICKS - 1) * TICK_DIV + TICK_DIV;

    typedef struct {
        int         start;
        logic [3:0] prev;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] out;
    } exp_t;

    typedef struct {
        int         cyc;
        logic [3:0] prev;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] out;
    } obs_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NUM_CH-1:0] pb_in = 4'hF;
    logic [NUM_CH-1:0] sig_debounced_out;
    logic [NUM_CH-1:0] rise_pulse;
    logic [NUM_CH-1:0] fall_pulse;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    exp_t       exp_q[$];
    obs_t       obs_q[$];
    logic [3:0] last_out = 4'h0;
    logic [3:0] model_out = 4'h0;

    pb_debounce #(
        .NUM_CH       (NUM_CH),
        .SYNC_STAGES  (SYNC_STAGES),
        .TICK_DIV     (TICK_DIV),
        .STABLE_TICKS (STABLE_TICKS)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .pb_in             (pb_in),
        .sig_debounced_out (sig_debounced_out),
        .rise_pulse        (rise_pulse),
        .fall_pulse        (fall_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if ((|rise_pulse) || (|fall_pulse))
            obs_q.push_back('{cyc, last_out, rise_pulse, fall_pulse, sig_debounced_out});
        last_out = sig_debounced_out;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic expect_event(input logic [3:0] rise, input logic [3:0] fall, input logic [3:0] out);
        exp_q.push_back('{cyc, model_out, rise, fall, out});
        model_out = out;
    endtask

    task automatic collect(input int budget, output bit ok, output obs_t o, output exp_t e);
        int k = 0;
        while (obs_q.size() == 0 && k < budget) begin
            step(1);
            k++;
        end
        ok = (obs_q.size() > 0) && (exp_q.size() > 0);
        if (ok) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
        end else begin
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        obs_t o; exp_t e; bit ok; int lat;
        for (int i = 0; i < 5; i++) begin
            step(1);
            tests_run++;
            if ({sig_debounced_out, rise_pulse, fall_pulse} !== 12'h000) begin
                tests_failed++;
                $display("[TB] FAIL reset_outputs: got out=%h rise=%h fall=%h, want all 0",
                         sig_debounced_out, rise_pulse, fall_pulse);
            end
        end
        model_out = 4'h0;
        reset = 1'b0;
        expect_event(4'hF, 4'h0, 4'hF);
        collect(40, ok, o, e);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("[TB] FAIL reset_rise_event: no pulse seen, want rise=F");
        end else begin
            lat = o.cyc - e.start;
            tests_run++;
            if ({o.prev, o.rise, o.fall, o.out} !== {e.prev, e.rise, e.fall, e.out}) begin
                tests_failed++;
                $display("[TB] FAIL reset_rise_fields: got prev=%h rise=%h fall=%h out=%h, want %h %h %h %h",
                         o.prev, o.rise, o.fall, o.out, e.prev, e.rise, e.fall, e.out);
            end
            tests_run++;
            if (lat > 2 + 8 + 4) begin
                tests_failed++;
                $display("[TB] FAIL reset_rise_latency: got %0d cycles, want <= 14", lat);
            end
        end
        step(4);
        tests_run++;
        if (obs_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL reset_single_pulse: got %0d extra pulses, want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    // Drives a new pin pattern, waits for the one expected event and checks it.
    task automatic test_event(input string name, input logic [3:0] pins,
                              input logic [3:0] rise, input logic [3:0] fall, input logic [3:0] out);
        obs_t o; exp_t e; bit ok; int lat;
        pb_in = pins;
        expect_event(rise, fall, out);
        collect(40, ok, o, e);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("[TB] FAIL %s_event: no pulse seen, want rise=%h fall=%h", name, rise, fall);
        end else begin
            lat = o.cyc - e.start - 1;
            tests_run++;
            if ({o.prev, o.rise, o.fall, o.out} !== {e.prev, e.rise, e.fall, e.out}) begin
                tests_failed++;
                $display("[TB] FAIL %s_fields: got prev=%h rise=%h fall=%h out=%h, want %h %h %h %h",
                         name, o.prev, o.rise, o.fall, o.out, e.prev, e.rise, e.fall, e.out);
            end
            tests_run++;
            if (lat < LAT_MIN || lat > LAT_MAX) begin
                tests_failed++;
                $display("[TB] FAIL %s_latency: got %0d cycles, want %0d..%0d", name, lat, LAT_MIN, LAT_MAX);
            end
        end
        step(4);
        tests_run++;
        if (obs_q.size() != 0 || sig_debounced_out !== model_out) begin
            tests_failed++;
            $display("[TB] FAIL %s_after: got %0d extra pulses out=%h, want 0 pulses out=%h",
                     name, obs_q.size(), sig_debounced_out, model_out);
            obs_q.delete();
        end
    endtask

    task automatic test_single_rise();
        step($urandom_range(0, 3));
        test_event("single_rise", pb_in | 4'h1, 4'h1, 4'h0, model_out | 4'h1);
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 10; i++) begin
            pb_in[1] = ~pb_in[1];
            step(3);
        end
        tests_run++;
        if (obs_q.size() != 0 || sig_debounced_out !== model_out) begin
            tests_failed++;
            $display("[TB] FAIL bounce_quiet: got %0d pulses out=%h, want 0 pulses out=%h",
                     obs_q.size(), sig_debounced_out, model_out);
            obs_q.delete();
        end
        test_event("bounce_settle", pb_in | 4'h2, 4'h2, 4'h0, model_out | 4'h2);
        step(20);
        tests_run++;
        if (obs_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL bounce_no_fall: got %0d pulses, want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_short_pulse();
        pb_in[2] = 1'b1;
        step(6);
        pb_in[2] = 1'b0;
        step(25);
        tests_run++;
        if (obs_q.size() != 0 || sig_debounced_out !== model_out) begin
            tests_failed++;
            $display("[TB] FAIL short_pulse: got %0d pulses out=%h, want 0 pulses out=%h",
                     obs_q.size(), sig_debounced_out, model_out);
            obs_q.delete();
        end
    endtask

    task automatic test_reset_mid_settle();
        test_event("ch0_release", pb_in & 4'hE, 4'h0, 4'h1, model_out & 4'hE);
        pb_in[0] = 1'b1;
        step(6);
        tests_run++;
        if (obs_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL mid_settle_early: got %0d pulses before reset, want 0", obs_q.size());
            obs_q.delete();
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            tests_run++;
            if ({sig_debounced_out, rise_pulse, fall_pulse} !== 12'h000) begin
                tests_failed++;
                $display("[TB] FAIL mid_reset_outputs: got out=%h rise=%h fall=%h, want all 0",
                         sig_debounced_out, rise_pulse, fall_pulse);
            end
        end
        tests_run++;
        if (obs_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset_pulse: got %0d pulses during reset, want 0", obs_q.size());
            obs_q.delete();
        end
        model_out = 4'h0;
        reset = 1'b0;
        test_event("post_reset", pb_in, pb_in, 4'h0, pb_in);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, want normal completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_event("setup_release", 4'h8, 4'h0, 4'h7, 4'h8);
        test_single_rise();
        test_bounce();
        test_short_pulse();
        test_event("ch3_fall", pb_in & 4'h7, 4'h0, 4'h8, model_out & 4'h7);
        test_reset_mid_settle();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
